// File: rtl/fish_spawn_scheduler.sv
// fish_spawn_scheduler
//   Fish/level progression for the fishing game. Player movement arms a
//   spawn delay, the fish then sweeps right-to-left, freezes on a hook
//   request, and each landed catch advances the level until the win state.
//   All state advances on the game-tick clock.
//
// Ports
//   clk          in   game-tick clock
//   rst          in   asynchronous active-high reset
//   move         in   player moving left or right
//   hook_req     in   up pressed while the hook overlaps the fish
//   landed       in   reeled fish reached the surface
//   fish_xpos    out  fish left-edge x (10 bits)
//   fish_ypos    out  fish centre y (10 bits), derived from level
//   level        out  current level 0..3
//   fish_visible out  fish drawn (swimming or hooked)
//   fish_hooked  out  fish is on the hook
//   level_done   out  one-tick pulse on level completion
//   win          out  all four levels completed
//
// Build option
//   SPAWN_SPEEDUP_EN : swim step becomes SPEED + level instead of SPEED.

module fish_spawn_scheduler #(
    parameter int unsigned X_START     = 798,
    parameter int unsigned X_MIN       = 144,
    parameter int unsigned SPAWN_DELAY = 400,
    parameter int unsigned SPEED       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move,
    input  logic       hook_req,
    input  logic       landed,
    output logic [9:0] fish_xpos,
    output logic [9:0] fish_ypos,
    output logic [1:0] level,
    output logic       fish_visible,
    output logic       fish_hooked,
    output logic       level_done,
    output logic       win
);

    localparam logic [9:0] XS = 10'(X_START);
    localparam logic [9:0] XM = 10'(X_MIN);
    localparam logic [9:0] SD = 10'(SPAWN_DELAY);

    typedef enum logic [2:0] {
        S_ARM,
        S_SWIM,
        S_HOOKED,
        S_LANDED,
        S_WIN
    } state_t;

    state_t     state, state_n;
    logic [9:0] delay_cnt, delay_cnt_n;
    logic [9:0] xpos_n;
    logic [1:0] level_n;
    logic [9:0] step;

    function automatic logic [9:0] ypos_for(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 10'd470;
            2'd1:    return 10'd380;
            2'd2:    return 10'd290;
            default: return 10'd200;
        endcase
    endfunction

    always_comb begin
`ifdef SPAWN_SPEEDUP_EN
        step = 10'(SPEED) + {8'b0, level};
`else
        step = 10'(SPEED);
`endif
    end

    always_comb begin
        state_n     = state;
        delay_cnt_n = delay_cnt;
        xpos_n      = fish_xpos;
        level_n     = level;
        case (state)
            S_ARM: begin
                xpos_n = XS;
                // Release does not need move on the releasing tick.
                if (delay_cnt == SD)
                    state_n = S_SWIM;
                else if (move && delay_cnt < SD)
                    delay_cnt_n = delay_cnt + 10'd1;
            end
            S_SWIM: begin
                // Hook beats wrap; wrap test runs before the subtract so
                // x never drops to or below X_MIN.
                if (hook_req) begin
                    state_n = S_HOOKED;
                end else if (fish_xpos <= XM + step) begin
                    xpos_n      = XS;
                    delay_cnt_n = '0;
                    state_n     = S_ARM;
                end else begin
                    xpos_n = fish_xpos - step;
                end
            end
            S_HOOKED: begin
                if (landed)
                    state_n = S_LANDED;
            end
            S_LANDED: begin
                if (level == 2'd3) begin
                    state_n = S_WIN;
                end else begin
                    level_n     = level + 2'd1;
                    xpos_n      = XS;
                    delay_cnt_n = '0;
                    state_n     = S_ARM;
                end
            end
            S_WIN: begin
                if (move) begin
                    level_n     = '0;
                    delay_cnt_n = '0;
                    xpos_n      = XS;
                    state_n     = S_ARM;
                end
            end
            default: state_n = S_ARM;
        endcase
    end

    // Flags are registered from the next state so they line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_ARM;
            delay_cnt    <= '0;
            fish_xpos    <= XS;
            fish_ypos    <= 10'd470;
            level        <= '0;
            fish_visible <= 1'b0;
            fish_hooked  <= 1'b0;
            level_done   <= 1'b0;
            win          <= 1'b0;
        end else begin
            state        <= state_n;
            delay_cnt    <= delay_cnt_n;
            fish_xpos    <= xpos_n;
            fish_ypos    <= ypos_for(level_n);
            level        <= level_n;
            fish_visible <= (state_n == S_SWIM) || (state_n == S_HOOKED);
            fish_hooked  <= (state_n == S_HOOKED);
            level_done   <= (state_n == S_LANDED);
            win          <= (state_n == S_WIN);
        end
    end

endmodule
